// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer feeding the 64-bit instruction register
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [63:0]           mem_data,
  output logic [63:0]           ir_data,
  output logic                  exec_start,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [7:0]            TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(8);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [63:0]             ir_q, ir_d;
  logic [7:0]              tcnt_q, tcnt_d;
  logic                    halt_pend_q;
  logic                    first_q, first_d;
  logic                    halt_any;
  logic                    target_unused;

  // Targets are forced to word alignment, so the low bits never matter.
  assign target_unused = ^branch_target[2:0];
  assign halt_any      = halt | halt_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      tcnt_q      <= '0;
      halt_pend_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      tcnt_q      <= tcnt_d;
      first_q     <= first_d;
      if (halt) halt_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tcnt_d  = tcnt_q;
    first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_any) begin
          state_d = S_HALTED;
        end else if (start) begin
          state_d = S_FETCH;
          tcnt_d  = '0;
        end
      end
      S_FETCH: begin
        // A response on the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = S_LOAD;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        state_d = S_EXEC;
        first_d = 1'b1;
      end
      S_EXEC: begin
        if (exec_done) begin
          pc_d    = branch_taken ? {branch_target[ADDR_WIDTH-1:3], 3'b000} : pc_q + PC_STEP;
          state_d = halt_any ? S_HALTED : S_FETCH;
          tcnt_d  = '0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_req    = (state_q == S_FETCH);
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign ir_data    = ir_q;
  assign exec_start = first_q && (state_q == S_EXEC);
  assign halted     = (state_q == S_HALTED);
  assign fault      = (state_q == S_FAULT);
  assign state      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk, rst_n, start, halt, mem_ready, exec_done, branch_taken;
  logic [63:0] mem_data;
  logic [31:0] branch_target;
  logic [7:0]  branch_target8;

  logic        mem_req, exec_start, halted, fault;
  logic [31:0] mem_addr, pc;
  logic [63:0] ir_data;
  logic [2:0]  state;

  logic        mem_req8, exec_start8, halted8, fault8;
  logic [7:0]  mem_addr8, pc8;
  logic [63:0] ir_data8;
  logic [2:0]  state8;

  logic [63:0] ir_reg;
  int          cyc;
  int          n_cmp, n_err;
  int          last_es;
  logic [31:0] model_pc;
  logic [7:0]  model_pc8;

  assign branch_target8 = branch_target[7:0];

  fetch_sequencer #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .ir_data(ir_data), .exec_start(exec_start), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .halted(halted), .fault(fault), .state(state)
  );

  fetch_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'h0), .TIMEOUT(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .mem_req(mem_req8), .mem_addr(mem_addr8), .mem_ready(mem_ready), .mem_data(mem_data),
    .ir_data(ir_data8), .exec_start(exec_start8), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target8),
    .pc(pc8), .halted(halted8), .fault(fault8), .state(state8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the instruction register: samples ir_data on every edge.
  always @(posedge clk) ir_reg <= ir_data;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    start = 0; halt = 0; mem_ready = 0; exec_done = 0; branch_taken = 0;
    mem_data = {$urandom, $urandom}; branch_target = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_pc = 32'h0;
    model_pc8 = 8'h0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // One instruction from its first FETCH cycle to just after its exec_done edge.
  task automatic run_instr(input int lat, input int elat, input bit br,
                           input logic [31:0] tgt, input logic [63:0] word, input bit hpulse);
    for (int i = 0; i <= lat; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || state !== 3'd1 || mem_addr !== model_pc) begin
        n_err++;
        $display("FAIL fetch_cycle%0d: req=%b state=%0d addr=%h, expected req=1 state=1 addr=%h",
                 i, mem_req, state, mem_addr, model_pc);
      end
      n_cmp++;
      if (mem_addr8 !== model_pc8) begin
        n_err++;
        $display("FAIL fetch_addr8: got %h expected %h", mem_addr8, model_pc8);
      end
      mem_ready = (i == lat);
      mem_data  = (i == lat) ? word : {$urandom, $urandom};
      halt      = hpulse && (i == 0);
      @(negedge clk);
    end
    mem_ready = 0; halt = 0; mem_data = {$urandom, $urandom};
    n_cmp++;
    if (state !== 3'd2 || mem_req !== 1'b0 || exec_start !== 1'b0 || fault !== 1'b0 || ir_data !== word) begin
      n_err++;
      $display("FAIL load: state=%0d req=%b es=%b fault=%b ir=%h, expected state=2 req=0 es=0 fault=0 ir=%h",
               state, mem_req, exec_start, fault, ir_data, word);
    end
    @(negedge clk);
    for (int j = 0; j <= elat; j++) begin
      n_cmp++;
      if (state !== 3'd3 || exec_start !== (j == 0) || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL exec_cycle%0d: state=%0d es=%b req=%b, expected state=3 es=%b req=0",
                 j, state, exec_start, mem_req, (j == 0));
      end
      if (j == 0) begin
        n_cmp++;
        if (ir_reg !== word) begin
          n_err++;
          $display("FAIL ir_reg_at_exec_start: got %h expected %h", ir_reg, word);
        end
        last_es = cyc;
      end
      exec_done     = (j == elat);
      branch_taken  = (j == elat) ? br : 1'($urandom);
      branch_target = (j == elat) ? tgt : $urandom;
      @(negedge clk);
    end
    exec_done = 0; branch_taken = 0;
    if (br) begin
      model_pc  = tgt & ~32'h7;
      model_pc8 = tgt[7:0] & ~8'h7;
    end else begin
      model_pc  = model_pc + 32'd8;
      model_pc8 = model_pc8 + 8'd8;
    end
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle_inputs();
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || pc !== 32'h0 || mem_addr !== 32'h0 || ir_data !== 64'h0 ||
        mem_req !== 1'b0 || exec_start !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: state=%0d pc=%h ir=%h req=%b es=%b h=%b f=%b, expected all zero",
               state, pc, ir_data, mem_req, exec_start, halted, fault);
    end
    @(negedge clk);
    rst_n = 1;
    model_pc = 0; model_pc8 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (state !== 3'd0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL idle_without_start: state=%0d req=%b, expected state=0 req=0", state, mem_req);
      end
    end
  endtask

  task automatic test_sequential();
    int prev_es;
    do_reset();
    do_start();
    prev_es = -1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (mem_addr !== 32'(k * 8)) begin
        n_err++;
        $display("FAIL seq_addr%0d: got %h expected %h", k, mem_addr, 32'(k * 8));
      end
      run_instr(0, 0, 1'b0, 32'h0, {$urandom, $urandom}, 1'b0);
      if (prev_es >= 0) begin
        n_cmp++;
        if (last_es - prev_es !== 3) begin
          n_err++;
          $display("FAIL seq_exec_start_period: got %0d expected 3", last_es - prev_es);
        end
      end
      prev_es = last_es;
    end
  endtask

  task automatic test_branch();
    run_instr(0, 0, 1'b1, 32'h10, {$urandom, $urandom}, 1'b0);
    n_cmp++;
    if (mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL branch_to_0x10: got %h expected 00000010", mem_addr);
    end
    run_instr(0, 0, 1'b1, 32'h105, {$urandom, $urandom}, 1'b0);
    n_cmp++;
    if (mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL branch_aligned: got %h expected 00000100", mem_addr);
    end
  endtask

  task automatic test_wait_states();
    run_instr(15, 1, 1'b0, 32'h0, {$urandom, $urandom}, 1'b0);
    run_instr(7, 2, 1'b0, 32'h0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 1'b1, 32'hF8, {$urandom, $urandom}, 1'b0);
    run_instr(0, 0, 1'b0, 32'h0, {$urandom, $urandom}, 1'b0);
    n_cmp++;
    if (mem_addr8 !== 8'h00 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL wrap: addr8=%h addr32=%h, expected 00 and 00000100", mem_addr8, mem_addr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), $urandom, {$urandom, $urandom}, 1'b0);
    end
  endtask

  task automatic test_halt();
    run_instr(2, 1, 1'b0, 32'h0, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      start = 1; mem_ready = 1;
      n_cmp++;
      if (halted !== 1'b1 || halted8 !== 1'b1 || mem_req !== 1'b0 || state !== 3'd4 || pc !== model_pc) begin
        n_err++;
        $display("FAIL halt_after_exec: h=%b h8=%b req=%b state=%0d pc=%h, expected 1 1 0 4 %h",
                 halted, halted8, mem_req, state, pc, model_pc);
      end
      @(negedge clk);
    end
    start = 0; mem_ready = 0;
  endtask

  task automatic test_halt_idle();
    do_reset();
    start = 1; halt = 1;
    @(negedge clk);
    start = 0; halt = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || state !== 3'd4) begin
        n_err++;
        $display("FAIL halt_in_idle: h=%b req=%b state=%0d, expected 1 0 4", halted, mem_req, state);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_req%0d: req=%b fault=%b, expected 1 0", i, mem_req, fault);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (fault !== 1'b1 || fault8 !== 1'b1 || mem_req !== 1'b0 || state !== 3'd5) begin
        n_err++;
        $display("FAIL timeout_fault%0d: fault=%b fault8=%b req=%b state=%0d, expected 1 1 0 5",
                 i, fault, fault8, mem_req, state);
      end
      start = 1; mem_ready = 1;
      @(negedge clk);
    end
    start = 0; mem_ready = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    run_instr(0, 0, 1'b1, 32'h40, {$urandom, $urandom}, 1'b0);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    @(negedge clk);
    n_cmp++;
    if (exec_start !== 1'b1 || pc !== 32'h40) begin
      n_err++;
      $display("FAIL pre_reset_exec: es=%b pc=%h, expected 1 00000040", exec_start, pc);
    end
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || pc !== 32'h0 || mem_addr !== 32'h0 || ir_data !== 64'h0 ||
        mem_req !== 1'b0 || exec_start !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d pc=%h ir=%h req=%b es=%b h=%b f=%b, expected all zero",
               state, pc, ir_data, mem_req, exec_start, halted, fault);
    end
    @(negedge clk);
    rst_n = 1;
    model_pc = 0; model_pc8 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (state !== 3'd0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL resume_needs_start: state=%0d req=%b, expected 0 0", state, mem_req);
      end
    end
    do_start();
    run_instr(1, 0, 1'b0, 32'h0, {$urandom, $urandom}, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_es = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_wait_states();
    test_wrap();
    test_random();
    test_halt();
    test_halt_idle();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the 64-bit instruction register. It issues word-aligned fetch requests to instruction memory and holds the returned word on `ir_data`, which feeds the instruction register's `in`; the instruction register samples it on every `clk` edge. It then signals the execute stage, waits for completion, and updates the program counter, either sequentially or to a branch target. It also handles halt requests and memory timeouts.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: program counter and memory address width.
- `RESET_PC`, 0: program counter value after reset; low 3 bits must be 0.
- `TIMEOUT`, 16: maximum number of `FETCH` cycles, 2..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave `IDLE` and begin fetching.
- `halt` in 1: stop request; takes effect at the next instruction boundary.
- `mem_req` out 1: fetch request.
- `mem_addr` out ADDR_WIDTH: fetch address; always equals `pc`.
- `mem_ready` in 1: memory returns `mem_data` this cycle.
- `mem_data` in 64: fetched instruction word.
- `ir_data` out 64: held instruction word, connected to the instruction register's `in`.
- `exec_start` out 1: one-cycle pulse; the instruction register output holds the new instruction.
- `exec_done` in 1: execute stage has finished the current instruction.
- `branch_taken` in 1: sampled with `exec_done`.
- `branch_target` in ADDR_WIDTH: sampled with `exec_done`.
- `pc` out ADDR_WIDTH: current program counter.
- `halted` out 1: high while in `HALTED`.
- `fault` out 1: high while in `FAULT` (fetch timeout).
- `state` out 3: state encoding, for debug.

## Operation
- States and encodings: `IDLE`=0, `FETCH`=1, `LOAD`=2, `EXEC`=3, `HALTED`=4, `FAULT`=5. Encodings 6 and 7 recover to `IDLE`.
- `halt_pend` is an internal flag, set by `halt` in any state and cleared only by reset.
- `IDLE`:
  - `halt` or `halt_pend` → `HALTED`; this takes priority over `start`.
  - Otherwise `start` → `FETCH`.
- `FETCH`:
  - `mem_req`=1.
  - If `mem_ready`=1: capture `mem_data` into `ir_data` and go to `LOAD`.
  - Otherwise increment the timeout counter. The counter clears on entry to `FETCH`.
  - If the counter equals `TIMEOUT`-1 and `mem_ready`=0 → `FAULT`.
  - `mem_ready` on the `TIMEOUT`-th cycle is still accepted.
- `LOAD`: lasts exactly one cycle, then → `EXEC`. At the closing edge the instruction register captures `ir_data`.
- `EXEC`:
  - `exec_start`=1 in the first `EXEC` cycle only.
  - Wait for `exec_done`; `exec_done` is allowed in that same first cycle.
  - On `exec_done`, update `pc`: `pc` ← `branch_taken` ? {`branch_target`[ADDR_WIDTH-1:3], 3'b000} : `pc`+8.
  - Then go to `HALTED` if `halt_pend` or `halt` is set, else to `FETCH`.
- `HALTED` and `FAULT` are terminal; only `rst_n` exits them.
- `pc` arithmetic is modulo 2^ADDR_WIDTH; `pc`+8 wraps to 0 silently.
- `mem_ready` and `mem_data` are ignored outside `FETCH`. `exec_done` is ignored outside `EXEC`.
- A `halt` during `FETCH` or `LOAD` does not abort the fetch. The instruction executes, then the sequencer halts.

## Timing
- Reset (`rst_n`=0) forces the following immediately, without waiting for a clock edge, regardless of state:
  - state=`IDLE`, `pc`=`mem_addr`=`RESET_PC`;
  - `ir_data`=0, `mem_req`=0, `exec_start`=0;
  - `halted`=0, `fault`=0, `halt_pend`=0, timeout counter=0.
- Outputs are decoded from registered state only; there are no combinational input-to-output paths.
- Latency with memory ready in the first `FETCH` cycle:
  - `FETCH`(1 cycle) → `LOAD`(1) → `EXEC`.
  - `exec_start` occurs 2 cycles after `FETCH` entry.
  - Minimum loop with single-cycle execute: 3 cycles per instruction.
- `mem_req` is held continuously from `FETCH` entry until the edge that samples `mem_ready`=1, or until the fault.
- `exec_start` is never high for two consecutive cycles.

## Test plan
- **Sequential run:**
  - Stimulus: reset with `RESET_PC`=0; `start` pulse; memory answers in the first cycle; `exec_done`=1 in the first `EXEC` cycle.
  - Required: `mem_addr` sequence 0, 8, 16, 24.
  - Required: `exec_start` every 3rd cycle.
  - Required: `ir_data` matches the memory word; the instruction register output holds that word in the `exec_start` cycle.
- **Branch:**
  - Stimulus: at `pc`=0x10, `exec_done` with `branch_taken`=1 and `branch_target`=0x105.
  - Required: next `mem_addr`=0x100.
- **Wait states and timeout:**
  - Stimulus: `mem_ready` arrives after 15 cycles of `mem_req` with `TIMEOUT`=16.
  - Required: normal `LOAD`, no fault.
  - Stimulus: `mem_ready` never arrives.
  - Required: `fault`=1 after exactly 16 `mem_req` cycles; `mem_req`=0 thereafter; `start` has no effect.
- **Halt mid-instruction:**
  - Stimulus: `halt` pulse during `FETCH`.
  - Required: that instruction still gets `exec_start`; after its `exec_done`, `halted`=1 and no further `mem_req`.
  - Stimulus: `start` and `halt` together in `IDLE`.
  - Required: `HALTED` immediately, with no fetch.
- **Wrap-around:**
  - Stimulus: `ADDR_WIDTH`=8, `pc`=0xF8, sequential `exec_done`.
  - Required: next `mem_addr`=0x00.
- **Asynchronous reset:**
  - Stimulus: assert `rst_n`=0 mid-cycle during `EXEC` after a branch.
  - Required: outputs return to reset values before the next `clk` edge; `pc`=`RESET_PC`; `start` is required to resume.
